// File: rtl/adder_alu_pipe_if.sv
// Handshake bundle for adder_alu_pipe: operation request channel in, result channel out.
// The arithmetic unit uses the slave modport and the operand source/result sink uses the master modport.
interface adder_alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_tag
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_tag
    );
endinterface

// File: rtl/adder_alu_pipe.sv
// Pipelined add/sub/inc/dec unit: one shared adder at the input, STAGES register slices,
// and a saturating counter of delivered results that overflowed.
module adder_alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_alu_pipe_if.slave  io,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ovf_count
);

    if (WIDTH < 2 || WIDTH > 128) begin : g_bad_width
        $fatal(1, "adder_alu_pipe: WIDTH must be in 2..128");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $fatal(1, "adder_alu_pipe: STAGES must be in 1..4");
    end

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_INC = 2'b10,
        OP_DEC = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic overflow;
        logic carry_out;
        logic zero;
        logic negative;
    } status_flags_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        status_flags_t    flags;
        logic [WIDTH-1:0] result;
    } stage_t;

    alu_op_e          op;
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    status_flags_t    flags_in;

    logic [STAGES-1:0] valid_q, valid_d, load;
    stage_t            data_q [STAGES];
    stage_t            data_d [STAGES];
    logic [CNT_W-1:0]  ovf_count_q, ovf_count_d;

    // Every operation folds into A + B' + cin so a single adder serves all four.
    always_comb begin
        op    = alu_op_e'(io.in_op);
        b_eff = '0;
        cin   = 1'b0;
        case (op)
            OP_ADD: begin b_eff = io.in_b;  cin = 1'b0; end
            OP_SUB: begin b_eff = ~io.in_b; cin = 1'b1; end
            OP_INC: begin b_eff = '0;       cin = 1'b1; end
            OP_DEC: begin b_eff = '1;       cin = 1'b0; end
            default: begin b_eff = '0;      cin = 1'b0; end
        endcase
        sum = {1'b0, io.in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        res = sum[WIDTH-1:0];
        flags_in.overflow  = (io.in_a[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != io.in_a[WIDTH-1]);
        flags_in.carry_out = sum[WIDTH];
        flags_in.zero      = (res == '0);
        flags_in.negative  = res[WIDTH-1];
    end

    // Stage k may load when out_ready is high or any slot from k to the end is empty;
    // this is the unrolled form of the per-stage ready chain, free of self-reference.
    always_comb begin
        load = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            load[k] = io.out_ready || (|(~valid_q & ({STAGES{1'b1}} << k)));
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load[0]) begin
            valid_d[0] = io.in_valid;
            if (io.in_valid) begin
                data_d[0].tag    = io.in_tag;
                data_d[0].flags  = flags_in;
                data_d[0].result = res;
            end
        end
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (load[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) data_d[k] = data_q[k-1];
            end
        end
    end

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (clr_cnt) begin
            ovf_count_d = '0;
        end else if (io.out_valid && io.out_ready && data_q[STAGES-1].flags.overflow
                     && ovf_count_q != '1) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            ovf_count_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) data_q[k] <= '0;
        end else begin
            valid_q     <= valid_d;
            ovf_count_q <= ovf_count_d;
            for (int unsigned k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
        end
    end

    assign io.in_ready   = load[0];
    assign io.out_valid  = valid_q[STAGES-1];
    assign io.out_result = data_q[STAGES-1].result;
    assign io.out_flags  = data_q[STAGES-1].flags;
    assign io.out_tag    = data_q[STAGES-1].tag;
    assign ovf_count     = ovf_count_q;

endmodule

// File: tb/tb_adder_alu_pipe.sv
// Self-checking bench for adder_alu_pipe: signed/unsigned arithmetic reference model with a
// FIFO scoreboard, directed corner vectors, random backpressure, stall, reset and counter checks.
module tb_adder_alu_pipe;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_cnt = 1'b0;
    logic [CNT_W-1:0] ovf_count;

    adder_alu_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    adder_alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (bus.slave),
        .clr_cnt   (clr_cnt),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        logic [3:0]  t;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_cnt = 0;
    logic rand_bp = 1'b0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_r;
    logic [3:0]  prev_f, prev_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: overflow from true signed range, carry from unsigned magnitude comparisons.
    function automatic logic [35:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        logic [31:0] r;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin s = sa + sb; r = a + b;     c = (longint'(a) + longint'(b)) > 64'hFFFF_FFFF; end
            2'd1: begin s = sa - sb; r = a - b;     c = (a >= b); end
            2'd2: begin s = sa + 1;  r = a + 32'd1; c = (a == 32'hFFFF_FFFF); end
            default: begin s = sa - 1; r = a - 32'd1; c = (a != 32'd0); end
        endcase
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {v, c, (r == 32'd0), r[31], r};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Single compare process: sampled on the falling edge, between handshake edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            check("ovf_count", ovf_count, exp_cnt);
            check("in_ready", bus.in_ready, (bus.out_ready || q.size() < STAGES));
            if (prev_stall) begin
                check("stall out_valid", bus.out_valid, 1);
                check("stall result", bus.out_result, prev_r);
                check("stall flags", bus.out_flags, prev_f);
                check("stall tag", bus.out_tag, prev_t);
            end
            if (q.size() == 0 && bus.out_valid) check("spurious out_valid", bus.out_valid, 0);
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("result", bus.out_result, e.r);
                check("flags", bus.out_flags, e.f);
                check("tag", bus.out_tag, e.t);
                if (clr_cnt) exp_cnt = 0;
                else if (e.f[3] && exp_cnt < CNT_MAX) exp_cnt++;
            end else if (clr_cnt) begin
                exp_cnt = 0;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t n;
                logic [35:0] m;
                m = model(bus.in_op, bus.in_a, bus.in_b);
                n.r = m[31:0];
                n.f = m[35:32];
                n.t = bus.in_tag;
                q.push_back(n);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_r = bus.out_result;
            prev_f = bus.out_flags;
            prev_t = bus.out_tag;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, output int waits);
        logic acc;
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_tag = tag;
        waits = 0;
        forever begin
            if (rand_bp) bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 500) begin
                check("issue timeout", 1, 0);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_dir(input string nm, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
        logic [35:0] m;
        int w, wc;
        m = model(op, a, b);
        check({nm, " model result"}, m[31:0], er);
        check({nm, " model flags"}, m[35:32], ef);
        issue(op, a, b, 4'h5, w);
        wc = 0;
        while (!bus.out_valid && wc < 50) begin
            @(posedge clk);
            #1;
            wc++;
        end
        check({nm, " latency"}, wc, STAGES - 1);
        check({nm, " result"}, bus.out_result, er);
        check({nm, " flags"}, bus.out_flags, ef);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, tot, k;
        bus.in_valid = 1'b0;
        bus.in_op = 2'd0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_result", bus.out_result, 0);
        check("reset out_flags", bus.out_flags, 0);
        check("reset out_tag", bus.out_tag, 0);
        check("reset ovf_count", ovf_count, 0);
        rst_n = 1'b1;
        check("in_ready after reset", bus.in_ready, 1);

        run_dir("add ovf", 2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
        check("ovf_count after add", ovf_count, 1);
        run_dir("sub eq", 2'd1, 32'd5, 32'd5, 32'h0000_0000, 4'b0110);
        run_dir("sub neg", 2'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0001);
        run_dir("inc wrap", 2'd2, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 4'b0110);
        run_dir("dec zero", 2'd3, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 4'b0001);
        run_dir("dec min", 2'd3, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 4'b1100);

        tot = 0;
        for (int i = 0; i < 20; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(), 4'(i), w);
            tot += w;
        end
        check("throughput stalls", tot, 0);

        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(), 4'(i % 16), w);
        end
        rand_bp = 1'b0;
        bus.out_ready = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain", q.size(), 0);

        bus.out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            issue(2'd0, 32'h7FFF_FFFF, 32'd1, 4'(i + 3), w);
            check("fill accept", w, 0);
        end
        bus.in_valid = 1'b1;
        bus.in_op = 2'd2;
        bus.in_a = 32'd9;
        @(negedge clk);
        check("full in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst out_result", bus.out_result, 0);
        check("midrst out_flags", bus.out_flags, 0);
        check("midrst out_tag", bus.out_tag, 0);
        check("midrst ovf_count", ovf_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("in_ready after release", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("no stale out_valid", bus.out_valid, 0);
        end

        for (int i = 0; i < 5; i++) issue(2'd0, 32'h7FFF_FFFF, 32'd1, 4'(i), w);
        repeat (STAGES + 2) @(posedge clk);
        #1;
        check("ovf_count saturated", ovf_count, 3);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("ovf_count cleared", ovf_count, 0);
        run_dir("ovf after clear", 2'd3, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 4'b1100);
        check("ovf_count one", ovf_count, 1);

        bus.out_ready = 1'b0;
        issue(2'd0, 32'h7FFF_FFFF, 32'd1, 4'hC, w);
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("held ovf result valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clear wins", ovf_count, 0);
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
